// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: types shared by the RAM access controller and its testbench.
package ram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; on a tie the requester not granted
// most recently wins. last_q = 1 means requester 1 was granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_q, last_d;

    always_comb begin
        grant[0] = req[0] & (~req[1] | last_q);
        grant[1] = req[1] & (~req[0] | ~last_q);
        last_d   = grant[1] ? 1'b1 : grant[0] ? 1'b0 : last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_q <= 1'b1;
        else          last_q <= last_d;
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sweeps the attached dual-port RAM to DEFAULT_VALUE after reset or
// on request, then arbitrates two write requesters and one read port onto it.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    DEPTH         = 64,
    parameter int                    OUTPUT_DELAY  = 1,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0,
    localparam int                   AW            = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  w0_valid,
    output logic                  w0_ready,
    input  logic [AW-1:0]         w0_addr,
    input  logic [DATA_WIDTH-1:0] w0_data,
    input  logic                  w1_valid,
    output logic                  w1_ready,
    input  logic [AW-1:0]         w1_addr,
    input  logic [DATA_WIDTH-1:0] w1_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [AW-1:0]         rd_addr,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mem_wea,
    output logic [AW-1:0]         mem_addra,
    output logic [DATA_WIDTH-1:0] mem_dia,
    output logic                  mem_reb,
    output logic [AW-1:0]         mem_addrb,
    input  logic [DATA_WIDTH-1:0] mem_dob
);

    localparam int VW = OUTPUT_DELAY == 0 ? 1 : OUTPUT_DELAY;

    ctrl_state_t           state_q, state_d;
    logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
    logic [AW-1:0]         addra_q;
    logic [DATA_WIDTH-1:0] dia_q;
    logic [VW-1:0]         vld_q;
    logic [1:0]            grant;
    logic                  run;

    assign run = state_q == RUN;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({w1_valid, w0_valid} & {2{run}}),
        .grant   (grant)
    );

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (!run) begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            state_d   = clr_cnt_q == AW'(DEPTH - 1) ? RUN : CLEAR;
        end else if (clear_req) begin
            clr_cnt_d = '0;
            state_d   = CLEAR;
        end
    end

    assign busy     = !run;
    assign w0_ready = grant[0];
    assign w1_ready = grant[1];
    assign rd_ready = run;

    // Port A keeps its last address/data when idle so it never floats to X.
    assign mem_wea   = !run | (|grant);
    assign mem_addra = !run ? clr_cnt_q : grant[1] ? w1_addr : grant[0] ? w0_addr : addra_q;
    assign mem_dia   = !run ? DEFAULT_VALUE : grant[1] ? w1_data : grant[0] ? w0_data : dia_q;
    assign mem_reb   = rd_valid & rd_ready;
    assign mem_addrb = rd_addr;

    assign rd_data_valid = OUTPUT_DELAY == 0 ? mem_reb : vld_q[VW-1];
    assign rd_data       = mem_dob;

    // The valid pipe is not flushed on a clear so in-flight reads still answer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            addra_q   <= '0;
            dia_q     <= '0;
            vld_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            addra_q   <= mem_addra;
            dia_q     <= mem_dia;
            vld_q     <= VW'({vld_q, mem_reb});
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: drives three controllers (read latency 0, 1, 2) with shared
// stimulus, each with its own RAM model, against a behavioural scoreboard.
module tb_ram_access_ctrl;

    localparam int         DW    = 8;
    localparam int         DEPTH = 64;
    localparam int         AW    = 6;
    localparam logic [7:0] DEF   = 8'hC3;

    logic          clk = 0, reset_n = 0, clear_req = 0;
    logic          w0_valid = 0, w1_valid = 0, rd_valid = 0;
    logic [AW-1:0] w0_addr = 0, w1_addr = 0, rd_addr = 0;
    logic [DW-1:0] w0_data = 0, w1_data = 0;
    logic [2:0]    busy, w0_ready, w1_ready, rd_ready, rd_data_valid, mem_wea, mem_reb;
    logic [AW-1:0] mem_addra [3];
    logic [AW-1:0] mem_addrb [3];
    logic [DW-1:0] mem_dia [3];
    logic [DW-1:0] mem_dob [3];
    logic [DW-1:0] rd_data [3];
    int            n_chk = 0, n_pass = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gen_od
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] p1, p2;
        ram_access_ctrl #(
            .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUTPUT_DELAY(g), .DEFAULT_VALUE(DEF)
        ) dut (
            .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .busy(busy[g]),
            .w0_valid(w0_valid), .w0_ready(w0_ready[g]), .w0_addr(w0_addr), .w0_data(w0_data),
            .w1_valid(w1_valid), .w1_ready(w1_ready[g]), .w1_addr(w1_addr), .w1_data(w1_data),
            .rd_valid(rd_valid), .rd_ready(rd_ready[g]), .rd_addr(rd_addr),
            .rd_data_valid(rd_data_valid[g]), .rd_data(rd_data[g]),
            .mem_wea(mem_wea[g]), .mem_addra(mem_addra[g]), .mem_dia(mem_dia[g]),
            .mem_reb(mem_reb[g]), .mem_addrb(mem_addrb[g]), .mem_dob(mem_dob[g])
        );
        always @(posedge clk) begin
            if (mem_wea[g]) mem[mem_addra[g]] <= mem_dia[g];
            if (mem_reb[g]) p1 <= mem[mem_addrb[g]];
            p2 <= p1;
        end
        assign mem_dob[g] = g == 0 ? mem[mem_addrb[g]] : g == 1 ? p1 : p2;
    end

    // Reference model: memory image, sweep progress, arbitration history, accepted reads.
    logic [7:0]    ref_mem [DEPTH];
    bit            m_clear = 1, m_last = 1;
    int            m_cnt = 0;
    logic [AW-1:0] m_la = 0;
    logic [7:0]    m_ld = 0;
    int            acc_c [$];
    logic [7:0]    acc_d [$];
    int            rp [3] = '{0, 0, 0};

    always @(negedge clk) begin : sb
        int            win;
        logic          wr, ev;
        logic [AW-1:0] wa;
        logic [7:0]    wd;
        if (!reset_n) begin
            m_clear = 1;
            m_cnt   = 0;
            m_last  = 1;
            for (int g = 0; g < 3; g++) rp[g] = acc_c.size();
        end else begin
            win = -1;
            if (!m_clear) begin
                if (w0_valid && w1_valid) win = m_last ? 0 : 1;
                else if (w0_valid) win = 0;
                else if (w1_valid) win = 1;
            end
            wr = m_clear || win >= 0;
            wa = m_clear ? AW'(m_cnt) : win == 1 ? w1_addr : win == 0 ? w0_addr : m_la;
            wd = m_clear ? DEF : win == 1 ? w1_data : win == 0 ? w0_data : m_ld;
            for (int g = 0; g < 3; g++) begin
                n_chk++;
                if (busy[g] !== m_clear || w0_ready[g] !== (win == 0) || w1_ready[g] !== (win == 1) ||
                    rd_ready[g] !== !m_clear || mem_wea[g] !== wr || mem_addra[g] !== wa ||
                    mem_dia[g] !== wd || mem_reb[g] !== (!m_clear && rd_valid) ||
                    (mem_reb[g] && mem_addrb[g] !== rd_addr))
                    $display("FAIL ctrl od%0d cyc %0d got busy=%b rdy=%b%b%b wea=%b addra=%0d dia=%h reb=%b exp busy=%b win=%0d wea=%b addra=%0d dia=%h",
                             g, cyc, busy[g], w0_ready[g], w1_ready[g], rd_ready[g], mem_wea[g],
                             mem_addra[g], mem_dia[g], mem_reb[g], m_clear, win, wr, wa, wd);
                else n_pass++;
            end
            if (!m_clear && rd_valid) begin
                acc_c.push_back(cyc);
                acc_d.push_back(ref_mem[rd_addr]);
            end
            for (int g = 0; g < 3; g++) begin
                ev = rp[g] < acc_c.size() && acc_c[rp[g]] + g == cyc;
                n_chk++;
                if (rd_data_valid[g] !== ev || (ev && rd_data[g] !== acc_d[rp[g]]))
                    $display("FAIL rd_resp od%0d cyc %0d got valid=%b data=%h exp valid=%b data=%h",
                             g, cyc, rd_data_valid[g], rd_data[g], ev, ev ? acc_d[rp[g]] : 8'h00);
                else n_pass++;
                if (ev) rp[g]++;
            end
            if (wr) ref_mem[wa] = wd;
            m_la = wa;
            m_ld = wd;
            if (win >= 0) m_last = win == 1;
            if (m_clear) begin
                if (m_cnt == DEPTH - 1) m_clear = 0;
                else m_cnt++;
            end else if (clear_req) begin
                m_clear = 1;
                m_cnt   = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 3'b111 || w0_ready !== 3'b0 || w1_ready !== 3'b0 || rd_ready !== 3'b0 || rd_data_valid !== 3'b0)
            $display("FAIL reset_values got busy=%b w0r=%b w1r=%b rdr=%b rdv=%b exp busy=111 others 000",
                     busy, w0_ready, w1_ready, rd_ready, rd_data_valid);
        else n_pass++;
    endtask

    task automatic test_sweep;
        int n = 0;
        tick();
        reset_n = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy[1]) break;
            n++;
        end
        n_chk++;
        if (n != 64) $display("FAIL sweep_len got %0d exp 64", n);
        else n_pass++;
        for (int a = 0; a < DEPTH; a++) begin
            tick();
            rd_valid = 1;
            rd_addr  = AW'(a);
        end
        tick();
        rd_valid = 0;
        repeat (3) tick();
        for (int g = 0; g < 3; g++) begin
            n_chk++;
            if (rp[g] != acc_c.size()) $display("FAIL sweep_drain od%0d got %0d exp %0d", g, rp[g], acc_c.size());
            else n_pass++;
        end
    endtask

    task automatic test_arbitration;
        tick();
        w0_valid = 1; w0_addr = 3; w0_data = 8'hA5;
        w1_valid = 1; w1_addr = 7; w1_data = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_chk++;
            if (w0_ready !== {3{k % 2 == 0}} || w1_ready !== {3{k % 2 == 1}})
                $display("FAIL grant_order step %0d got w0r=%b w1r=%b exp w%0d", k, w0_ready, w1_ready, k % 2);
            else n_pass++;
        end
        tick();
        w0_valid = 0; w1_valid = 0;
        rd_valid = 1; rd_addr = 3;
        tick();
        rd_addr = 7;
        @(negedge clk);
        n_chk++;
        if (rd_data_valid[1] !== 1'b1 || rd_data[1] !== 8'hA5)
            $display("FAIL arb_read3 got valid=%b data=%h exp 1 a5", rd_data_valid[1], rd_data[1]);
        else n_pass++;
        tick();
        rd_valid = 0;
        @(negedge clk);
        n_chk++;
        if (rd_data_valid[1] !== 1'b1 || rd_data[1] !== 8'h5A)
            $display("FAIL arb_read7 got valid=%b data=%h exp 1 5a", rd_data_valid[1], rd_data[1]);
        else n_pass++;
    endtask

    task automatic test_same_cycle;
        repeat (3) tick();
        w0_valid = 1; w0_addr = 5; w0_data = 8'h11;
        rd_valid = 1; rd_addr = 5;
        tick();
        w0_valid = 0;
        @(negedge clk);
        n_chk++;
        if (rd_data_valid[2] !== 1'b0) $display("FAIL lat2_early got valid=%b exp 0", rd_data_valid[2]);
        else n_pass++;
        tick();
        rd_valid = 0;
        @(negedge clk);
        n_chk++;
        if (rd_data_valid[2] !== 1'b1 || rd_data[2] !== DEF)
            $display("FAIL same_cycle_old got valid=%b data=%h exp 1 %h", rd_data_valid[2], rd_data[2], DEF);
        else n_pass++;
        tick();
        @(negedge clk);
        n_chk++;
        if (rd_data_valid[2] !== 1'b1 || rd_data[2] !== 8'h11)
            $display("FAIL next_cycle_new got valid=%b data=%h exp 1 11", rd_data_valid[2], rd_data[2]);
        else n_pass++;
    endtask

    task automatic test_clear;
        int n = 1;
        repeat (3) tick();
        rd_valid = 1; rd_addr = 7;
        tick();
        rd_addr = 9; clear_req = 1;
        w1_valid = 1; w1_addr = 9; w1_data = 8'h77;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            n_chk++;
            if (w1_ready[g] !== 1'b1 || mem_wea[g] !== 1'b1 || mem_addra[g] !== 6'd9 || mem_dia[g] !== 8'h77)
                $display("FAIL clear_write od%0d got rdy=%b wea=%b addra=%0d dia=%h exp 1 1 9 77",
                         g, w1_ready[g], mem_wea[g], mem_addra[g], mem_dia[g]);
            else n_pass++;
        end
        tick();
        clear_req = 0; w1_valid = 0; rd_valid = 0; w0_valid = 1; w0_addr = 1;
        @(negedge clk);
        n_chk++;
        if (busy !== 3'b111 || w0_ready !== 3'b0 || rd_ready !== 3'b0)
            $display("FAIL clear_busy got busy=%b w0r=%b rdr=%b exp 111 000 000", busy, w0_ready, rd_ready);
        else n_pass++;
        for (int i = 0; i < 200; i++) begin
            tick();
            clear_req = n == 10;
            @(negedge clk);
            if (!busy[1]) break;
            n++;
        end
        clear_req = 0;
        n_chk++;
        if (n != 64) $display("FAIL clear_sweep_len got %0d exp 64", n);
        else n_pass++;
        tick();
        w0_valid = 0;
        rd_valid = 1; rd_addr = 9;
        tick();
        rd_valid = 0;
        repeat (3) tick();
        for (int g = 0; g < 3; g++) begin
            n_chk++;
            if (rp[g] != acc_c.size()) $display("FAIL clear_drain od%0d got %0d exp %0d", g, rp[g], acc_c.size());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        bit found = 0;
        repeat (2) tick();
        rd_valid = 1; rd_addr = 3;
        tick();
        rd_valid = 0; reset_n = 0;
        #1;
        n_chk++;
        if (rd_data_valid !== 3'b0 || busy !== 3'b111 || rd_ready !== 3'b0)
            $display("FAIL reset_mid_read got rdv=%b busy=%b rdr=%b exp 000 111 000", rd_data_valid, busy, rd_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = busy[1] && mem_addra[1] == 6'd30;
        end
        n_chk++;
        if (!found) $display("FAIL reach_addr30 got none exp 30");
        else n_pass++;
        #1 reset_n = 0;
        #1;
        n_chk++;
        if (busy !== 3'b111 || w0_ready !== 3'b0 || w1_ready !== 3'b0 || rd_data_valid !== 3'b0 || mem_addra[1] !== 6'd0)
            $display("FAIL reset_mid_sweep got busy=%b w0r=%b w1r=%b rdv=%b addra=%0d exp 111 000 000 000 0",
                     busy, w0_ready, w1_ready, rd_data_valid, mem_addra[1]);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(negedge clk);
        n_chk++;
        if (mem_addra[1] !== 6'd0) $display("FAIL restart_addr got %0d exp 0", mem_addra[1]);
        else n_pass++;
        for (int i = 0; i < 200; i++) begin
            if (!busy[1]) break;
            n++;
            @(negedge clk);
        end
        n_chk++;
        if (n != 64) $display("FAIL restart_sweep_len got %0d exp 64", n);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        bit ev;
        for (int i = 0; i < 8; i++) begin
            tick();
            w0_valid = 1; w0_addr = AW'(i); w0_data = 8'(i * 17 + 1);
        end
        tick();
        w0_valid = 0;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) tick();
            rd_valid = k < 8;
            rd_addr  = AW'(k);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                ev = k >= g && k < g + 8;
                n_chk++;
                if (rd_data_valid[g] !== ev || (ev && rd_data[g] !== 8'((k - g) * 17 + 1)))
                    $display("FAIL b2b od%0d slot %0d got valid=%b data=%h exp valid=%b data=%h",
                             g, k, rd_data_valid[g], rd_data[g], ev, 8'((k - g) * 17 + 1));
                else n_pass++;
            end
        end
        rd_valid = 0;
    endtask

    task automatic test_random;
        bit t0 = 1, t1 = 1;
        for (int t = 0; t < 400; t++) begin
            tick();
            if (!w0_valid || t0) begin
                w0_valid = 1'($urandom_range(0, 1));
                w0_addr  = AW'($urandom_range(0, 7));
                w0_data  = 8'($urandom);
            end
            if (!w1_valid || t1) begin
                w1_valid = 1'($urandom_range(0, 1));
                w1_addr  = AW'($urandom_range(0, 7));
                w1_data  = 8'($urandom);
            end
            rd_valid  = 1'($urandom_range(0, 1));
            rd_addr   = AW'($urandom_range(0, 7));
            clear_req = $urandom_range(0, 149) == 0;
            @(negedge clk);
            t0 = w0_valid && w0_ready[0];
            t1 = w1_valid && w1_ready[0];
        end
        tick();
        w0_valid = 0; w1_valid = 0; rd_valid = 0; clear_req = 0;
        repeat (3) tick();
        for (int g = 0; g < 3; g++) begin
            n_chk++;
            if (rp[g] != acc_c.size()) $display("FAIL random_drain od%0d got %0d exp %0d", g, rp[g], acc_c.size());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_arbitration();
        test_same_cycle();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got no finish exp finish by 500000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: word width.
REQ-002 The block SHALL have parameter DEPTH, default 64: word count (power of two, ≥4); AW = $clog2(DEPTH).
REQ-003 The block SHALL have parameter OUTPUT_DELAY, default 1: the read latency (0, 1 or 2) of the attached mem_simple_dual_port.
REQ-004 The block SHALL have parameter DEFAULT_VALUE, default 0: the DATA_WIDTH-bit clear pattern.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk (input, 1, sole clock, rising edge), then reset_n (input, 1, async active-low reset).
REQ-006 The requester ports SHALL be: clear_req in 1 (clear request pulse); busy out 1 (clear in progress); w0_valid in 1, w0_ready out 1, w0_addr in AW, w0_data in DATA_WIDTH (write requester 0); w1_valid in 1, w1_ready out 1, w1_addr in AW, w1_data in DATA_WIDTH (write requester 1); rd_valid in 1, rd_ready out 1, rd_addr in AW (read request); rd_data_valid out 1, rd_data out DATA_WIDTH (read response).
REQ-007 The memory-side ports SHALL be: mem_wea out 1; mem_addra out AW; mem_dia out DATA_WIDTH; mem_reb out 1; mem_addrb out AW; mem_dob in DATA_WIDTH. clka and clkb of the memory both connect to clk.

Function
REQ-008 The FSM SHALL have exactly two states: CLEAR and RUN.
REQ-009 In CLEAR the block SHALL drive mem_wea=1, mem_addra=clr_cnt and mem_dia=DEFAULT_VALUE each cycle, incrementing clr_cnt from 0 to DEPTH-1, then enter RUN on the next cycle; the sweep takes DEPTH cycles.
REQ-010 In CLEAR, busy SHALL be 1 and w0_ready, w1_ready and rd_ready SHALL all be 0.
REQ-011 In RUN, clear_req=1 SHALL set clr_cnt=0 and enter CLEAR next cycle; any write granted in that same cycle still completes. clear_req during CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-012 In RUN, write arbitration SHALL be combinational round-robin: a single valid requester is granted; if both are valid, the requester not granted most recently wins; the last-grant pointer resets to 1, so w0 wins the first tie.
REQ-013 A write SHALL complete in the cycle valid&ready=1: mem_wea=1 with the winner's addr/data; at most one ready is high per cycle; the loser holds its request (valid/addr/data stable until ready).
REQ-014 In RUN, rd_ready SHALL be 1; mem_addrb=rd_addr and mem_reb=rd_valid&rd_ready.
REQ-015 rd_data_valid SHALL assert exactly OUTPUT_DELAY cycles after an accepted read (combinationally the same cycle when OUTPUT_DELAY=0), with rd_data=mem_dob; back-to-back reads SHALL give back-to-back responses, via a shift register of OUTPUT_DELAY valid bits.
REQ-016 Read and write of the same address in the same cycle SHALL return the old data; a read one cycle later SHALL return the new data.
REQ-017 Reads accepted before entering CLEAR SHALL still produce their responses, carrying the data captured at the time of the read.
REQ-018 When the ram_access_ctrl is idle in RUN, mem_wea SHALL be 0 and mem_addra/mem_dia SHALL hold their last values (no X).

Reset
REQ-019 Asserting reset_n=0 SHALL immediately set: state=CLEAR, clr_cnt=0, last-grant=1, valid shift register=0, rd_data_valid=0, busy=1, all ready outputs=0.
REQ-020 Reset asserted mid-sweep or mid-read SHALL abort the operation; after release the sweep restarts from address 0 and pending responses are discarded.
REQ-021 Memory contents SHALL NOT be assumed after reset until busy falls.

Structure
REQ-022 The shared package ram_ctrl_pkg SHALL hold the state enum ctrl_state_t {CLEAR, RUN}.
REQ-023 The two-input round-robin arbiter SHALL be the sub-module rr_arb2 (req[1:0], grant[1:0], last-grant register).
REQ-024 The controller SHALL NOT instantiate the memory; mem_simple_dual_port is connected alongside it at the next level up.

Verification
REQ-025 Release reset with DEPTH=64, OUTPUT_DELAY=1 -> busy=1 for exactly 64 cycles with mem_addra=0..63 and mem_dia=DEFAULT_VALUE; then every read returns DEFAULT_VALUE.
REQ-026 w0 and w1 held valid for 4 cycles (addr 3/data 0xA5 and addr 7/data 0x5A) -> grant order w0, w1, w0, w1; reading addr 3 returns 0xA5 and addr 7 returns 0x5A.
REQ-027 Write addr 5=0x11 and read addr 5 in the same cycle -> old value (DEFAULT_VALUE); read next cycle -> 0x11; OUTPUT_DELAY=2 -> rd_data_valid exactly 2 cycles after the accept.
REQ-028 clear_req pulsed in RUN during a write and reads -> the write completes, in-flight read responses arrive, busy rises next cycle, 64-cycle sweep follows, all readys are 0 meanwhile.
REQ-029 reset_n pulled low at sweep address 30 -> outputs go to reset values immediately; after release the sweep restarts at address 0 and runs a full 64 cycles.
REQ-030 Reads back-to-back to addresses 0..7 with OUTPUT_DELAY=0, 1 and 2 -> 8 consecutive rd_data_valid cycles, in order, at the correct latency.
